// File: rtl/regfile_sweep_reader_pkg.sv
// Shared definitions for the register-file sweep reader: geometry of the 32x32
// register file and the sweep FSM state encoding.
package regfile_defs;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/regfile_index_counter.sv
// Modulo-NUM_REGS register index counter with load, increment and a compare
// against the latched last index of the sweep range.
module regfile_index_counter #(
    parameter int NUM_REGS = regfile_defs::NUM_REGS,
    parameter int ADDR_W   = regfile_defs::REG_ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] idx_next,
    output logic              is_last
);

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;

    // Explicit wrap keeps the arithmetic correct when NUM_REGS is not a power of two.
    assign idx_next = (idx_q == ADDR_W'(NUM_REGS - 1)) ? '0 : idx_q + ADDR_W'(1);
    assign idx      = idx_q;
    assign is_last  = (idx_q == last_q);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        idx_d  = idx_q;
        last_d = last_q;
        if (load) begin
            idx_d  = first_reg;
            last_d = last_reg;
        end else if (inc) begin
            idx_d = idx_next;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (ctrl_reset) begin
            idx_q  <= '0;
            last_q <= '0;
        end else begin
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_sweep_reader.sv
// Read-side sweeper: walks register-file read port B over an inclusive, wrapping
// index range and streams each value out over a valid/ready interface.
module regfile_sweep_reader #(
    parameter int NUM_REGS = regfile_defs::NUM_REGS,
    parameter int ADDR_W   = regfile_defs::REG_ADDR_W,
    parameter int DATA_W   = regfile_defs::REG_DATA_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] ctrl_readReg,
    input  logic [DATA_W-1:0] data_readReg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    import regfile_defs::*;

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_load, cnt_inc;
    logic [ADDR_W-1:0] cnt_idx, cnt_idx_next;
    logic              cnt_is_last;

    regfile_index_counter #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_index_counter (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .first_reg  (first_reg),
        .last_reg   (last_reg),
        .idx        (cnt_idx),
        .idx_next   (cnt_idx_next),
        .is_last    (cnt_is_last)
    );

    always_comb begin
        state_d     = state_q;
        read_addr_d = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;

        if (abort) begin
            // Abort drops any word in flight, including one handshaken this cycle.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_load    = 1'b1;
                        read_addr_d = first_reg;
                        busy_d      = 1'b1;
                        state_d     = ST_READ;
                    end
                end
                ST_READ: begin
                    out_data_d  = data_readReg;
                    out_index_d = cnt_idx;
                    out_last_d  = cnt_is_last;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (out_last_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            cnt_inc     = 1'b1;
                            read_addr_d = cnt_idx_next;
                            state_d     = ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q     <= ST_IDLE;
            read_addr_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_addr_q <= read_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ctrl_readReg = read_addr_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_index    = out_index_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_regfile_sweep_reader.sv
// Directed self-checking bench for regfile_sweep_reader with a combinational
// register-file model on read port B.
module tb_regfile_sweep_reader;

    logic        clock;
    logic        ctrl_reset;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  ctrl_readReg;
    logic [31:0] data_readReg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    regfile_sweep_reader dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .start        (start),
        .abort        (abort),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file contents: r0 reads as zero, every other register holds a unique pattern.
    function automatic logic [31:0] reg_val(input logic [4:0] i);
        return (i == 5'd0) ? 32'h0 : (32'h1000_0000 + 32'(i) * 32'h0000_0111);
    endfunction

    assign data_readReg = reg_val(ctrl_readReg);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Follows a running sweep from the current cycle, checking each word and the done pulse.
    task automatic collect(input logic [4:0] f, input int n, input string nm);
        int         k = 0;
        logic [4:0] e;
        for (int c = 0; c < 200 && k < n; c++) begin
            e = f + 5'(k);
            if (out_valid) begin
                check({nm, "_idx"},  32'(out_index), 32'(e));
                check({nm, "_data"}, out_data, reg_val(e));
                check({nm, "_last"}, 32'(out_last), 32'(k == n - 1));
                check({nm, "_addr_hold"}, 32'(ctrl_readReg), 32'd0);
                k++;
            end else begin
                check({nm, "_addr_read"}, 32'(ctrl_readReg), 32'(e));
            end
            tick();
        end
        check({nm, "_count"}, 32'(k), 32'(n));
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_busy_in_done"}, 32'(busy), 32'd1);
        check({nm, "_valid_in_done"}, 32'(out_valid), 32'd0);
        tick();
        check({nm, "_done_clr"}, 32'(done), 32'd0);
        check({nm, "_busy_clr"}, 32'(busy), 32'd0);
        check({nm, "_valid_clr"}, 32'(out_valid), 32'd0);
    endtask

    task automatic sweep(input logic [4:0] f, input logic [4:0] l, input string nm);
        logic [4:0] d;
        d = l - f;
        out_ready = 1'b1;
        pulse_start(f, l);
        check({nm, "_busy"}, 32'(busy), 32'd1);
        collect(f, int'(d) + 1, nm);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_addr"},  32'(ctrl_readReg), 32'd0);
        check({nm, "_valid"}, 32'(out_valid), 32'd0);
        check({nm, "_data"},  out_data, 32'd0);
        check({nm, "_index"}, 32'(out_index), 32'd0);
        check({nm, "_last"},  32'(out_last), 32'd0);
        check({nm, "_busy"},  32'(busy), 32'd0);
        check({nm, "_done"},  32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        ctrl_reset = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        first_reg  = 5'd0;
        last_reg   = 5'd0;
        out_ready  = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        ctrl_reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Plain range, then a wrapping range that passes through r0, then a full sweep.
        sweep(5'd3, 5'd5, "t1");
        sweep(5'd30, 5'd1, "t2");
        sweep(5'd7, 5'd6, "t3");

        // Back-pressure: consumer stalls 10 cycles while start pulses try to restart.
        out_ready = 1'b0;
        pulse_start(5'd10, 5'd12);
        tick();
        check("t4_first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            start     = i[0];
            first_reg = 5'd20;
            last_reg  = 5'd25;
            tick();
            check("t4_stall_valid", 32'(out_valid), 32'd1);
            check("t4_stall_idx",   32'(out_index), 32'd10);
            check("t4_stall_data",  out_data, reg_val(5'd10));
        end
        start     = 1'b0;
        out_ready = 1'b1;
        collect(5'd10, 3, "t4");

        // Abort during the second word's HOLD while the consumer is ready.
        out_ready = 1'b1;
        pulse_start(5'd4, 5'd8);
        tick();
        check("t5_w0_idx", 32'(out_index), 32'd4);
        tick();
        tick();
        check("t5_w1_valid", 32'(out_valid), 32'd1);
        check("t5_w1_idx",   32'(out_index), 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_valid", 32'(out_valid), 32'd0);
        check("t5_abort_busy",  32'(busy), 32'd0);
        check("t5_abort_done",  32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_post_done",  32'(done), 32'd0);
            check("t5_post_valid", 32'(out_valid), 32'd0);
        end
        sweep(5'd20, 5'd21, "t5_restart");

        // Reset while READ owns the port.
        pulse_start(5'd9, 5'd11);
        check("t6_read_addr", 32'(ctrl_readReg), 32'd9);
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        check_reset_outputs("t6");
        tick();
        check("t6_stays_idle", 32'(out_valid), 32'd0);

        // Single-word sweep of r0.
        sweep(5'd0, 5'd0, "t7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
